// File: rtl/regfile_op_sequencer.sv
// Register-file micro-op sequencer: READ, EXEC, WRITE after accept, one op every 4 cycles.
// Write enable is asserted in the third cycle after accept; instr_ready stays low until the op retires.
module regfile_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [7:0]        instr_imm,
    output logic [ADDR_W-1:0] rf_addr_read1,
    output logic [ADDR_W-1:0] rf_addr_read2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_write,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              done,
    output logic              flag_zero,
    output logic              flag_carry
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_LDI  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;

    state_t              r_state;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_rs1;
    logic [ADDR_W-1:0]   r_rs2;
    logic [7:0]          r_imm;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_carry;
    logic                r_ready;
    logic                r_we;
    logic                r_done;
    logic                r_flag_z;
    logic                r_flag_c;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_res;
    logic                w_carry;
    logic [DATA_W-1:0]   w_imm_ext;
    logic                w_writes;
    logic                w_sets_flags;

    assign w_imm_ext    = {{(DATA_W-8){1'b0}}, r_imm};
    assign w_writes     = (r_op <= OP_MOV);
    assign w_sets_flags = (r_op <= OP_CMP);

    // Carry and borrow both fall out of bit DATA_W of a zero-extended add/subtract.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum   = {1'b0, r_opa} + {1'b0, r_opb};
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                w_sum   = {1'b0, r_opa} - {1'b0, r_opb};
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_AND:  w_res = r_opa & r_opb;
            OP_OR:   w_res = r_opa | r_opb;
            OP_XOR:  w_res = r_opa ^ r_opb;
            OP_NOT:  w_res = ~r_opa;
            OP_SHL: begin
                w_res   = {r_opa[DATA_W-2:0], 1'b0};
                w_carry = r_opa[DATA_W-1];
            end
            OP_SHR: begin
                w_res   = {1'b0, r_opa[DATA_W-1:1]};
                w_carry = r_opa[0];
            end
            OP_LDI:  w_res = w_imm_ext;
            OP_ADDI: begin
                w_sum   = {1'b0, r_opa} + {1'b0, w_imm_ext};
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_MOV:  w_res = r_opa;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ready  <= 1'b1;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_op    <= instr_op;
                        r_rd    <= instr_rd;
                        r_rs1   <= instr_rs1;
                        r_rs2   <= instr_rs2;
                        r_imm   <= instr_imm;
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_opa   <= rf_data1;
                    r_opb   <= rf_data2;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                    r_carry  <= w_carry;
                    r_we     <= w_writes;
                    r_done   <= 1'b1;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_sets_flags) begin
                        r_flag_z <= r_zero;
                        r_flag_c <= r_carry;
                    end
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready   = r_ready;
    assign rf_addr_read1 = r_rs1;
    assign rf_addr_read2 = r_rs2;
    assign rf_we         = r_we;
    assign rf_addr_write = r_rd;
    assign rf_data_in    = r_result;
    assign done          = r_done;
    assign flag_zero     = r_flag_z;
    assign flag_carry    = r_flag_c;
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: drives micro-ops into a modelled register file and
// checks every cycle against an op-level reference that schedules each retirement 3 edges after accept.
`timescale 1ns/1ps
module tb_regfile_op_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [3:0]  instr_rd = '0;
    logic [3:0]  instr_rs1 = '0;
    logic [3:0]  instr_rs2 = '0;
    logic [7:0]  instr_imm = '0;
    logic [3:0]  rf_addr_read1, rf_addr_read2, rf_addr_write;
    logic [15:0] rf_data1, rf_data2, rf_data_in;
    logic        rf_we, done, flag_zero, flag_carry;

    logic [15:0] brf    [16] = '{default: '0};
    logic [15:0] ref_rf [16] = '{default: '0};

    int total = 0, bad = 0;
    int cyc = 0, we_cnt = 0, done_cnt = 0, acc_cnt = 0;

    bit          m_pend = 0, m_wr = 0, m_fl = 0, m_c = 0;
    int          m_acc = 0;
    logic [15:0] m_res = '0;
    logic [3:0]  m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    bit          f_z = 0, f_c = 0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .rf_addr_read1(rf_addr_read1), .rf_addr_read2(rf_addr_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rf_we(rf_we), .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in),
        .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    // Register file the sequencer talks to: async read, write on the rising edge.
    assign rf_data1 = brf[rf_addr_read1];
    assign rf_data2 = brf[rf_addr_read2];
    always @(posedge clk) begin
        if (rf_we) begin
            brf[rf_addr_write] <= rf_data_in;
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Returns {writes, sets_flags, carry, result[15:0]}.
    function automatic logic [18:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] imm);
        int unsigned ua, ub, ui, s;
        bit w, f, c;
        logic [15:0] r;
        ua = a; ub = b; ui = imm; s = 0; w = 1; f = 1; c = 0; r = '0;
        case (op)
            4'd0:  begin s = ua + ub; r = 16'(s); c = (s > 65535); end
            4'd1:  begin r = 16'(ua - ub); c = (ua < ub); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin r = 16'(ua * 2); c = (ua >= 32768); end
            4'd7:  begin r = 16'(ua / 2); c = (ua % 2 == 1); end
            4'd8:  r = 16'(ui);
            4'd9:  begin s = ua + ui; r = 16'(s); c = (s > 65535); end
            4'd10: r = a;
            4'd11: begin r = 16'(ua - ub); c = (ua < ub); w = 0; end
            default: begin w = 0; f = 0; end
        endcase
        return {w, f, c, r};
    endfunction

    always @(posedge clk) begin : model
        logic [18:0] x;
        cyc = cyc + 1;
        if (!reset_n) begin
            m_pend = 0; f_z = 0; f_c = 0;
        end else if (m_pend) begin
            if (cyc == m_acc + 3) begin
                if (m_wr) ref_rf[m_rd] = m_res;
                if (m_fl) begin f_z = (m_res == 16'h0); f_c = m_c; end
                m_pend = 0;
            end
        end else if (instr_valid) begin
            x = alu(instr_op, ref_rf[instr_rs1], ref_rf[instr_rs2], instr_imm);
            m_wr = x[18]; m_fl = x[17]; m_c = x[16]; m_res = x[15:0];
            m_rd = instr_rd; m_rs1 = instr_rs1; m_rs2 = instr_rs2;
            m_acc = cyc; m_pend = 1; acc_cnt++;
        end
    end

    always @(negedge clk) begin : cmp
        int ph;
        ph = cyc - m_acc;
        chk("ready", instr_ready, !m_pend);
        chk("we", rf_we, m_pend && ph == 2 && m_wr);
        chk("done", done, m_pend && ph == 2);
        chk("flag_zero", flag_zero, f_z);
        chk("flag_carry", flag_carry, f_c);
        if (m_pend && ph == 0) begin
            chk("addr_read1", rf_addr_read1, m_rs1);
            chk("addr_read2", rf_addr_read2, m_rs2);
        end
        if (m_pend && ph == 2 && m_wr) begin
            chk("addr_write", rf_addr_write, m_rd);
            chk("data_in", rf_data_in, m_res);
        end
    end

    task automatic scramble();
        instr_op = 4'($urandom); instr_rd = 4'($urandom); instr_rs1 = 4'($urandom);
        instr_rs2 = 4'($urandom); instr_imm = 8'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [7:0] imm);
        int n;
        n = 0;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("issue_timeout", instr_ready, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        scramble();
    endtask

    task automatic run_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [7:0] imm);
        issue(op, rd, rs1, rs2, imm);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int w0, d0, a0;
        logic [15:0] old5, old3;
        logic [7:0] imms [12];

        reset_n = 1'b0;
        instr_valid = 1'b1; instr_op = 4'd8; instr_rd = 4'd7; instr_imm = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", flag_zero, 0);
        chk("rst_carry", flag_carry, 0);
        chk("rst_waddr", rf_addr_write, 0);
        chk("rst_wdata", rf_data_in, 0);
        chk("rst_raddr1", rf_addr_read1, 0);
        instr_valid = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_no_accept_r7", brf[7], 16'h0000);

        run_op(4'd8, 4'd1, 4'd0, 4'd0, 8'h12);
        run_op(4'd8, 4'd2, 4'd0, 4'd0, 8'h34);
        run_op(4'd0, 4'd3, 4'd1, 4'd2, 8'h00);
        chk("t1_r3", brf[3], 16'h0046);
        chk("t1_zero", flag_zero, 0);
        chk("t1_carry", flag_carry, 0);
        chk("t1_we_cnt", we_cnt, 3);

        run_op(4'd8, 4'd1, 4'd0, 4'd0, 8'hFF);
        run_op(4'd1, 4'd2, 4'd0, 4'd1, 8'h00);
        chk("t2_r2", brf[2], 16'hFF01);
        chk("t2_sub_carry", flag_carry, 1);
        run_op(4'd0, 4'd3, 4'd2, 4'd2, 8'h00);
        chk("t2_r3", brf[3], 16'hFE02);
        chk("t2_add_carry", flag_carry, 1);
        chk("t2_zero", flag_zero, 0);

        w0 = we_cnt; d0 = done_cnt; old3 = brf[3];
        run_op(4'd11, 4'd3, 4'd1, 4'd1, 8'h00);
        chk("t3_cmp_no_we", we_cnt, w0);
        chk("t3_cmp_done", done_cnt, d0 + 1);
        chk("t3_cmp_zero", flag_zero, 1);
        chk("t3_cmp_carry", flag_carry, 0);
        chk("t3_r3_kept", brf[3], old3);
        chk("t3_r1_kept", brf[1], 16'h00FF);
        run_op(4'd13, 4'd3, 4'd1, 4'd2, 8'h55);
        chk("t3_nop_zero", flag_zero, 1);
        chk("t3_nop_carry", flag_carry, 0);
        chk("t3_nop_done", done_cnt, d0 + 2);
        chk("t3_nop_no_we", we_cnt, w0);

        a0 = acc_cnt; w0 = we_cnt; old5 = brf[5];
        for (int i = 0; i < 12; i++) begin
            imms[i] = 8'($urandom);
            instr_op = 4'd8; instr_rd = 4'(4 + i); instr_imm = imms[i];
            instr_valid = 1'b1;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_accepts", acc_cnt - a0, 3);
        chk("t4_writes", we_cnt - w0, 3);
        chk("t4_r4", brf[4], {8'h00, imms[0]});
        chk("t4_r8", brf[8], {8'h00, imms[4]});
        chk("t4_r12", brf[12], {8'h00, imms[8]});
        chk("t4_r5_kept", brf[5], old5);

        run_op(4'd8, 4'd1, 4'd0, 4'd0, 8'h01);
        run_op(4'd7, 4'd2, 4'd1, 4'd0, 8'h00);
        chk("t5_shr_r2", brf[2], 16'h0000);
        chk("t5_shr_zero", flag_zero, 1);
        chk("t5_shr_carry", flag_carry, 1);
        run_op(4'd8, 4'd6, 4'd0, 4'd0, 8'h80);
        for (int i = 0; i < 8; i++) run_op(4'd6, 4'd6, 4'd6, 4'd0, 8'h00);
        run_op(4'd9, 4'd4, 4'd6, 4'd0, 8'h01);
        chk("t5_r4", brf[4], 16'h8001);
        run_op(4'd6, 4'd3, 4'd4, 4'd0, 8'h00);
        chk("t5_shl_r3", brf[3], 16'h0002);
        chk("t5_shl_carry", flag_carry, 1);
        chk("t5_shl_zero", flag_zero, 0);

        w0 = we_cnt; d0 = done_cnt; old5 = brf[5];
        issue(4'd0, 4'd5, 4'd1, 4'd2, 8'h00);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("t6_no_we", we_cnt, w0);
        chk("t6_no_done", done_cnt, d0);
        chk("t6_r5_kept", brf[5], old5);
        chk("t6_ready", instr_ready, 1);
        chk("t6_zero", flag_zero, 0);
        chk("t6_carry", flag_carry, 0);
        run_op(4'd0, 4'd5, 4'd1, 4'd2, 8'h00);
        chk("t6_after_r5", brf[5], 16'h0001);

        for (int k = 0; k < 60; k++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            repeat ($urandom_range(3, 5)) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) chk("rf_final", brf[i], ref_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Client-side master for the 16x16 dual-read/single-write register file.
- Accepts one register-to-register micro-op at a time over a valid/ready handshake.
- Per op: drives the two read addresses, captures the operands, computes a 16-bit ALU result and writes it back through the file's write port.
- Sits between the CPU decode stage and the register file; it is the only driver of the file's we/addr_write/data_in.

Parameters:
- DATA_W, 16, datapath and register width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  micro-op present.
- instr_ready  out  1  sequencer can accept a micro-op.
- instr_op  in  4  opcode.
- instr_rd  in  ADDR_W  destination register.
- instr_rs1  in  ADDR_W  source register 1.
- instr_rs2  in  ADDR_W  source register 2.
- instr_imm  in  8  immediate, zero-extended to DATA_W.
- rf_addr_read1  out  ADDR_W  to register file read port 1.
- rf_addr_read2  out  ADDR_W  to register file read port 2.
- rf_data1  in  DATA_W  asynchronous read data, port 1.
- rf_data2  in  DATA_W  asynchronous read data, port 2.
- rf_we  out  1  register file write enable.
- rf_addr_write  out  ADDR_W  write address.
- rf_data_in  out  DATA_W  write data.
- done  out  1  one-cycle pulse when a micro-op retires.
- flag_zero  out  1  last retired result == 0.
- flag_carry  out  1  last retired carry/borrow/shift-out.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all latched fields, operands and result cleared.
  - Outputs: rf_we=0, done=0, flag_zero=0, flag_carry=0, all addresses/data 0, instr_ready=1.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at an edge: latch op/rd/rs1/rs2/imm; go to READ.
- READ:
  - rf_addr_read1/2 = latched rs1/rs2.
  - At the closing edge, capture rf_data1/2 into operand registers; go to EXEC.
- EXEC: compute the result and flags combinationally from the operands; register them at the closing edge; go to WRITE.
- WRITE:
  - rf_addr_write=rd, rf_data_in=result.
  - rf_we=1 for this single cycle unless the op is CMP or NOP.
  - done=1; flag_zero/flag_carry update at the closing edge; return to IDLE.
- instr_ready=0 in READ/EXEC/WRITE. Payload changes while not ready are ignored.
- Throughput: one op per 4 cycles, with back-to-back acceptance in the cycle after WRITE.
- Latency: accept edge T0; rf_we high during the cycle after T2; the register file write occurs at edge T3.
- Read-after-write needs no special handling: the next op's READ cycle is after T3.
- Opcodes (16-bit arithmetic, result truncated):
  - 0 ADD rs1+rs2, carry=bit16.
  - 1 SUB rs1-rs2, carry=borrow (rs1<rs2 unsigned).
  - 2 AND; 3 OR; 4 XOR; 5 NOT rs1. Carry=0 for opcodes 2-5.
  - 6 SHL rs1 by 1, carry=old bit15.
  - 7 SHR rs1 by 1 (logical), carry=old bit0.
  - 8 LDI rd=imm; carry=0.
  - 9 ADDI rs1+imm; carry=bit16.
  - 10 MOV rd=rs1; carry=0.
  - 11 CMP: computes as SUB and updates flags; no write.
  - 12-15 NOP: no write, flags unchanged, done still pulses.
- flag_zero = (result==0) for opcodes 0-11. Flags hold their value between ops.
- rd equal to rs1 or rs2 is legal; operands were captured before the write.
- Reset mid-operation (any state): op is abandoned; rf_we drops immediately; no write and no done pulse.
- instr_valid arriving while reset_n=0 is not accepted.

Test Plan:
- Reset, then LDI r1,0x12; LDI r2,0x34; ADD r3,r1,r2 -> r3=0x0046, zero=0, carry=0; rf_we high exactly 1 cycle per op, 3 edges after accept.
- LDI r1,0xFF; SUB r2,r0,r1 -> r2=0xFF01, carry=1; then ADD r3,r2,r2 -> r3=0xFE02, carry=1, zero=0.
- CMP r1,r1 (r1=0x00FF) -> rf_we never asserts, done pulses once, zero=1, carry=0; registers unchanged; a following NOP leaves flags at zero=1, carry=0.
- instr_valid held high for 12 cycles with a new LDI payload every cycle -> exactly 3 accepted (one per 4 cycles); instr_ready low in READ/EXEC/WRITE; only payloads present on accept edges are written.
- LDI r1,0x01; SHR r2,r1 -> r2=0x0000, zero=1, carry=1; SHL r3,r4 with r4=0x8001 -> r3=0x0002, carry=1.
- Issue ADD r5,r1,r2, pull reset_n low during EXEC (DUT reset only) -> rf_we stays 0, no done, r5 unchanged, instr_ready=1, flags 0; the op issued after release completes normally.
